sort_stream_wrapper: RTL

- Streaming front end for the parallel bitonic sorter `bitonic_sort_top`, which is instantiated inside this block.
- Accepts elements serially on a valid/ready input, buffers up to 2**LOG_INPUT of them, and pads partial frames.
- Launches one sort per frame and streams the sorted elements out on a valid/ready output with frame delimiting.
- Adds partial-frame support, backpressure, frame counting and a sorter watchdog, none of which the bare parallel sorter provides.

---
 rtl/sort_stream_wrapper_pkg.sv | 29 ++
 rtl/sort_stream_wrapper_if.sv | 33 +++
 rtl/bitonic_sort_top.sv | 74 +++++++
 rtl/sort_stream_wrapper.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/sort_stream_wrapper_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sort_stream_wrapper_pkg
// Description : Shared types and helper functions for the streaming sorter
//               front end and its parallel sorter core.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package sort_stream_wrapper_pkg;

    // Input-side FSM states.
    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2
    } state_t;

    // Number of sorter slots for a given log2 width.
    function automatic int slot_count(input int log_n);
        return 1 << log_n;
    endfunction

    // Width needed to hold an element count of 0..2**log_n.
    function automatic int count_width(input int log_n);
        return log_n + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sort_stream_wrapper_if.sv
`default_nettype none
// ============================================================================
// Module      : sort_stream_wrapper_if
// Description : Input and output valid/ready streams of the sorter front end.
// Ports       : in_valid/in_ready/in_data/in_last   - element input stream
//               out_valid/out_ready/out_data/out_last - sorted output stream
//               modport master : stream source/sink (environment side)
//               modport slave  : the sorter front end
// Revision    : 1.0 - initial release
// ============================================================================
interface sort_stream_wrapper_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_last;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface
`default_nettype wire

// File: rtl/bitonic_sort_top.sv
`default_nettype none
// ============================================================================
// Module      : bitonic_sort_top
// Description : Parallel bitonic sorting network over 2**LOG_INPUT elements.
//               The network is evaluated combinationally from x and the
//               result is registered; y_valid follows x_valid by one cycle.
// Ports       : clk, rst           - clock, synchronous active-high reset
//               x_valid, x         - packed input vector (slot i at i*DW)
//               y, y_valid         - packed sorted vector and its strobe
// Revision    : 1.0 - initial release
// ============================================================================
module bitonic_sort_top
    import sort_stream_wrapper_pkg::*;
#(
    parameter int LOG_INPUT  = 5,
    parameter int DATA_WIDTH = 32,
    parameter bit ASCENDING  = 1'b1
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          x_valid,
    input  logic [slot_count(LOG_INPUT)*DATA_WIDTH-1:0]   x,
    output logic [slot_count(LOG_INPUT)*DATA_WIDTH-1:0]   y,
    output logic                                          y_valid
);
    localparam int N = slot_count(LOG_INPUT);

    logic [DATA_WIDTH-1:0] w_net [N];
    logic [DATA_WIDTH-1:0] w_tmp;
    logic                  w_up;
    int                    w_l;

    // Classic bitonic network: stage k merges sequences of length k, pass j
    // compares elements j apart; direction alternates with bit k of index.
    always_comb begin
        w_tmp = '0;
        w_up  = 1'b0;
        w_l   = 0;
        for (int i = 0; i < N; i++) begin
            w_net[i] = x[i*DATA_WIDTH +: DATA_WIDTH];
        end
        for (int k = 2; k <= N; k = k * 2) begin
            for (int j = k / 2; j > 0; j = j / 2) begin
                for (int i = 0; i < N; i++) begin
                    w_l = i ^ j;
                    if (w_l > i) begin
                        w_up = ((i & k) == 0) ? ASCENDING : !ASCENDING;
                        if ((w_net[i] > w_net[w_l]) == w_up) begin
                            w_tmp      = w_net[i];
                            w_net[i]   = w_net[w_l];
                            w_net[w_l] = w_tmp;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_valid <= 1'b0;
            y       <= '0;
        end else begin
            y_valid <= x_valid;
            if (x_valid) begin
                for (int i = 0; i < N; i++) begin
                    y[i*DATA_WIDTH +: DATA_WIDTH] <= w_net[i];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sort_stream_wrapper.sv
`default_nettype none
// ============================================================================
// Module      : sort_stream_wrapper
// Description : Streaming front end for bitonic_sort_top. Collects up to
//               2**LOG_INPUT elements per frame, pads short frames, launches
//               one sort per frame and drains exactly the real elements with
//               frame delimiting. Includes a sorter watchdog and frame count.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               bus (slave)   - input and output valid/ready streams
//               busy          - not in FILL, or output buffer non-empty
//               timeout_err   - sticky watchdog flag
//               frame_count   - frames fully drained (wraps at 2**16)
// Revision    : 1.0 - initial release
// ============================================================================
module sort_stream_wrapper
    import sort_stream_wrapper_pkg::*;
#(
    parameter int LOG_INPUT      = 5,
    parameter int DATA_WIDTH     = 32,
    parameter bit ASCENDING      = 1'b1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    sort_stream_wrapper_if.slave   bus,
    output logic                   busy,
    output logic                   timeout_err,
    output logic [15:0]            frame_count
);
    localparam int N       = slot_count(LOG_INPUT);
    localparam int COUNT_W = count_width(LOG_INPUT);
    localparam int WAIT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    // Pads must sort behind every real element.
    localparam logic [DATA_WIDTH-1:0] PAD = ASCENDING ? '1 : '0;

    state_t                 state_q;
    logic [LOG_INPUT-1:0]   wr_idx_q;
    logic [COUNT_W-1:0]     count_q;
    logic [DATA_WIDTH-1:0]  ibuf_q [N];
    logic [DATA_WIDTH-1:0]  obuf_q [N];
    logic                   x_valid_q;
    logic [WAIT_W-1:0]      wait_cnt_q;
    logic                   timeout_q;
    logic [COUNT_W-1:0]     out_cnt_q;
    logic [LOG_INPUT-1:0]   rd_idx_q;
    logic [15:0]            frame_cnt_q;

    logic [N*DATA_WIDTH-1:0] x_d;
    logic [N*DATA_WIDTH-1:0] y_w;
    logic                    y_valid_w;
    logic                    out_valid_w;
    logic                    out_last_w;

    bitonic_sort_top #(
        .LOG_INPUT  (LOG_INPUT),
        .DATA_WIDTH (DATA_WIDTH),
        .ASCENDING  (ASCENDING)
    ) u_sorter (
        .clk     (clk),
        .rst     (rst),
        .x_valid (x_valid_q),
        .x       (x_d),
        .y       (y_w),
        .y_valid (y_valid_w)
    );

    // Slots beyond the frame length are padded; ibuf/count are frozen
    // outside FILL so x is stable while the sorter samples it.
    always_comb begin
        x_d = '0;
        for (int i = 0; i < N; i++) begin
            x_d[i*DATA_WIDTH +: DATA_WIDTH] = (COUNT_W'(i) < count_q) ? ibuf_q[i] : PAD;
        end
    end

    assign out_valid_w   = (out_cnt_q != '0);
    assign out_last_w    = out_valid_w && (COUNT_W'(rd_idx_q) == out_cnt_q - COUNT_W'(1));
    assign bus.in_ready  = (state_q == ST_FILL) && !rst;
    assign bus.out_valid = out_valid_w;
    assign bus.out_last  = out_last_w;
    assign bus.out_data  = out_valid_w ? obuf_q[rd_idx_q] : '0;
    assign busy          = (state_q != ST_FILL) || out_valid_w;
    assign timeout_err   = timeout_q;
    assign frame_count   = frame_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_FILL;
            wr_idx_q    <= '0;
            count_q     <= '0;
            x_valid_q   <= 1'b0;
            wait_cnt_q  <= '0;
            timeout_q   <= 1'b0;
            out_cnt_q   <= '0;
            rd_idx_q    <= '0;
            frame_cnt_q <= '0;
        end else begin
            x_valid_q <= 1'b0;
            case (state_q)
                ST_FILL: begin
                    if (bus.in_valid) begin
                        ibuf_q[wr_idx_q] <= bus.in_data;
                        if (bus.in_last || (wr_idx_q == LOG_INPUT'(N - 1))) begin
                            count_q  <= COUNT_W'(wr_idx_q) + COUNT_W'(1);
                            wr_idx_q <= '0;
                            state_q  <= ST_LAUNCH;
                        end else begin
                            wr_idx_q <= wr_idx_q + LOG_INPUT'(1);
                        end
                    end
                end
                ST_LAUNCH: begin
                    // Output buffer must be free before its contents get replaced.
                    if (out_cnt_q == '0) begin
                        x_valid_q  <= 1'b1;
                        wait_cnt_q <= '0;
                        state_q    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (y_valid_w) begin
                        for (int i = 0; i < N; i++) begin
                            if (COUNT_W'(i) < count_q) begin
                                obuf_q[i] <= y_w[i*DATA_WIDTH +: DATA_WIDTH];
                            end
                        end
                        out_cnt_q <= count_q;
                        rd_idx_q  <= '0;
                        state_q   <= ST_FILL;
                    end else if ((TIMEOUT_CYCLES != 0) &&
                                 (wait_cnt_q == WAIT_W'(TIMEOUT_CYCLES - 1))) begin
                        timeout_q <= 1'b1;
                        state_q   <= ST_FILL;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
                    end
                end
                default: state_q <= ST_FILL;
            endcase

            // Drain runs independently of the input FSM; it never overlaps a
            // capture because capture requires an empty output buffer.
            if (out_valid_w && bus.out_ready) begin
                if (out_last_w) begin
                    out_cnt_q   <= '0;
                    frame_cnt_q <= frame_cnt_q + 16'd1;
                end else begin
                    rd_idx_q <= rd_idx_q + LOG_INPUT'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire
